rf_wr_arbiter: RTL and testbench
================================

# rf_wr_arbiter

Write-port arbiter and read-bypass controller for the 32-bit, 16-entry `RegisterFile`. It shares the register file's single write port between two write-back requesters (requester 0: ALU result, requester 1: load/memory result) using round-robin arbitration with a valid/ready handshake. It drives the register file's write controls from a registered stage. It forwards an in-flight write onto the read data paths so that a read always returns the newest value.

## Interface
- `DBITS`, 32, data width; matches `RegisterFile`.
- `ABITS`, 4, register index width; the file has 2^ABITS words.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `hold`  in  1  when 1, no request is granted this cycle.
- `req0_valid`  in  1  requester 0 has a write pending.
- `req0_ready`  out  1  requester 0 write accepted this cycle.
- `req0_ind`  in  ABITS  requester 0 destination index.
- `req0_data`  in  DBITS  requester 0 write data.
- `req1_valid`, `req1_ready`, `req1_ind`, `req1_data`: same as requester 0, for requester 1.
- `wrtEn`  out  1  to `RegisterFile` write enable; registered.
- `wrtInd`  out  ABITS  to `RegisterFile` write index; registered.
- `dIn`  out  DBITS  to `RegisterFile` write data; registered.
- `rdInd0`, `rdInd1`  in  ABITS  read indices; the same values presented to `RegisterFile`.
- `rfOut0`, `rfOut1`  in  DBITS  raw `RegisterFile` read data.
- `dOut0`, `dOut1`  out  DBITS  resolved read data to the datapath.

## Operation
- **State:** priority pointer `ptr` with two states.
  - PRI0: requester 0 wins a tie.
  - PRI1: requester 1 wins a tie.
- **Grant (combinational):**
  - `req0_ready = rst_n & !hold & req0_valid & (!req1_valid | ptr==PRI0)`.
  - `req1_ready` is symmetric.
  - At most one ready is high in any cycle.
  - A ready is never high without its matching valid.
- **Pointer update, on each grant:**
  - Grant to 0 moves `ptr` to PRI1.
  - Grant to 1 moves `ptr` to PRI0.
  - With no grant, `ptr` holds.
  - A lone requester is granted every cycle regardless of `ptr`.
- **Write stage:**
  - On a grant, the next edge loads `wrtEn=1` and copies `wrtInd`/`dIn` from the granted requester.
  - With no grant, `wrtEn=0` and `wrtInd`/`dIn` hold their previous values.
- **Requester protocol:**
  - A requester must hold `valid`, `ind` and `data` stable until it sees `ready`.
  - It may drop `valid` only after the handshake.
- **Same-index collision:**
  - Both requesters target the same index: both writes go out in successive cycles, in arbitration order.
  - The second write's value is final.
- **`hold`:**
  - Suppresses grants only; `ptr` does not move.
  - A write already in the stage still completes (`wrtEn` was set in the prior cycle).
- **Reset (asynchronous assert, while `rst_n=0`):**
  - `wrtEn=0`, `wrtInd=0`, `dIn=0`, `ptr=PRI0`.
  - Both readies are 0.
  - `dOut0`/`dOut1` equal `rfOut0`/`rfOut1`.
  - An in-flight write registered before reset is dropped.

## Timing
- Grant to `wrtEn` high: 1 cycle.
- `wrtEn` high to `RegisterFile` contents updated: the same rising edge that ends the `wrtEn` cycle.
- Total request-accepted to committed latency: 2 edges.
- Sustained throughput: 1 write per cycle. Under continuous contention, each requester gets one grant every 2 cycles.
- Readies and `dOut*` are combinational. `wrtEn`, `wrtInd`, `dIn` and `ptr` are flops.
- `rst_n` deassertion is synchronized externally; the first grant may occur in the first cycle after release.

## Configuration
- Macro: `RF_ARB_FWD_EN`.
- **Defined:**
  - `dOutN = (wrtEn && wrtInd==rdIndN) ? dIn : rfOutN`, for N = 0, 1.
  - A read issued in the same cycle as the committing write returns the new data, independent of `RegisterFile` read/write ordering.
- **Undefined:**
  - `dOutN = rfOutN` unconditionally.
  - The datapath must not read an index until the cycle after its write commits.

## Test plan
- Reset: `rst_n=0` mid-operation with `wrtEn=1` -> `wrtEn`/`wrtInd`/`dIn` all 0 immediately; no write to the file; both readies 0; `ptr=PRI0` after release.
- Lone requester: `req0` writes 2 to r6 -> `req0_ready` high in the same cycle; next cycle `wrtEn=1`, `wrtInd=6`, `dIn=2`; read of r6 two edges later returns 2.
- Contention: both valid for 4 cycles, `req0` -> r8=5 then r9=7, `req1` -> r8=33 then r10=1 -> grant order 0,1,0,1; final r8=33, r9=7, r10=1.
- Hold: both valid, `hold=1` for 3 cycles -> no readies, `wrtEn=0`, `ptr` unchanged; after release the first grant goes to the pointer's requester.
- Forwarding with `RF_ARB_FWD_EN`: r6=2, write r6=9 with `rdInd0=6` during the `wrtEn` cycle -> `dOut0=9`. Without the macro, `dOut0` equals `rfOut0`.
- Idle: no valids for 5 cycles -> `wrtEn=0` throughout; `wrtInd`/`dIn` hold their last values; `dOut*` track `rfOut*`.

Source files
------------

// File: rtl/rf_wr_arbiter.sv
// rtl/rf_wr_arbiter.sv - two-requester write-port arbiter and read bypass for RegisterFile
//
// Shares the single RegisterFile write port between two write-back
// requesters (0: ALU result, 1: load result). Arbitration is round-robin
// with a valid/ready handshake, and the write controls come from a
// registered stage.
//
// Optional feature macro: RF_ARB_FWD_EN
//   defined   : an in-flight write (wrtEn) whose index matches a read index
//               is forwarded onto that read path (dOutN = dIn).
//   undefined : dOutN = rfOutN; the datapath must not read an index until
//               the cycle after its write commits.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   hold                    suppresses all grants for the cycle
//   reqN_valid/ready        requester N handshake (ready is combinational)
//   reqN_ind/data           requester N destination index / write data
//   wrtEn, wrtInd, dIn      registered write controls to RegisterFile
//   rdInd0/1, rfOut0/1      read indices and raw RegisterFile read data
//   dOut0/1                 resolved read data to the datapath

module rf_wr_arbiter #(
  parameter int DBITS = 32,
  parameter int ABITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [ABITS-1:0] req0_ind,
  input  logic [DBITS-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [ABITS-1:0] req1_ind,
  input  logic [DBITS-1:0] req1_data,
  output logic             wrtEn,
  output logic [ABITS-1:0] wrtInd,
  output logic [DBITS-1:0] dIn,
  input  logic [ABITS-1:0] rdInd0,
  input  logic [ABITS-1:0] rdInd1,
  input  logic [DBITS-1:0] rfOut0,
  input  logic [DBITS-1:0] rfOut1,
  output logic [DBITS-1:0] dOut0,
  output logic [DBITS-1:0] dOut1
);

  // Priority pointer: names the requester that wins a tie.
  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } ptr_t;

  ptr_t ptr;
  ptr_t ptr_nxt;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PRI0;
    end else begin
      ptr <= ptr_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic: the pointer passes priority to the other requester
  // after every grant, and stays put when nothing is granted (idle or hold).
  // ---------------------------------------------------------------------
  always_comb begin
    ptr_nxt = ptr;
    if (req0_ready) begin
      ptr_nxt = PRI1;
    end else if (req1_ready) begin
      ptr_nxt = PRI0;
    end
  end

  // ---------------------------------------------------------------------
  // Output logic: grants. rst_n is folded in so no ready can escape while
  // reset is asserted, even though the pointer is already PRI0 then.
  // A lone requester wins regardless of the pointer; the pointer only
  // breaks ties, so the two readies are mutually exclusive.
  // ---------------------------------------------------------------------
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n && !hold) begin
      req0_ready = req0_valid && (!req1_valid || (ptr == PRI0));
      req1_ready = req1_valid && (!req0_valid || (ptr == PRI1));
    end
  end

  // ---------------------------------------------------------------------
  // Write stage. Index and data hold their previous values when idle so
  // the bus does not toggle needlessly; only wrtEn qualifies them.
  // Reset clears wrtEn asynchronously, which drops any in-flight write.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrtEn  <= 1'b0;
      wrtInd <= '0;
      dIn    <= '0;
    end else if (req0_ready) begin
      wrtEn  <= 1'b1;
      wrtInd <= req0_ind;
      dIn    <= req0_data;
    end else if (req1_ready) begin
      wrtEn  <= 1'b1;
      wrtInd <= req1_ind;
      dIn    <= req1_data;
    end else begin
      wrtEn  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Read resolution.
  // ---------------------------------------------------------------------
`ifdef RF_ARB_FWD_EN
  // The stage's write lands in the file at the end of the wrtEn cycle, so
  // a same-cycle read would otherwise see the old word (or depend on the
  // file's read/write ordering). Forwarding dIn removes that dependence.
  always_comb begin
    dOut0 = rfOut0;
    dOut1 = rfOut1;
    if (wrtEn && (wrtInd == rdInd0)) begin
      dOut0 = dIn;
    end
    if (wrtEn && (wrtInd == rdInd1)) begin
      dOut1 = dIn;
    end
  end
`else
  always_comb begin
    dOut0 = rfOut0;
    dOut1 = rfOut1;
  end
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb/tb_rf_wr_arbiter.sv - directed self-checking bench for rf_wr_arbiter
module tb_rf_wr_arbiter;

  localparam int DBITS = 32;
  localparam int ABITS = 4;

  logic             clk;
  logic             rst_n;
  logic             hold;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [ABITS-1:0] req0_ind, req1_ind;
  logic [DBITS-1:0] req0_data, req1_data;
  logic             wrtEn;
  logic [ABITS-1:0] wrtInd;
  logic [DBITS-1:0] dIn;
  logic [ABITS-1:0] rdInd0, rdInd1;
  logic [DBITS-1:0] rfOut0, rfOut1;
  logic [DBITS-1:0] dOut0, dOut1;

  int errors = 0;
  int checks = 0;

  // Register file model: write at the rising edge that ends the wrtEn cycle.
  logic [DBITS-1:0] rf [16];

  rf_wr_arbiter #(.DBITS(DBITS), .ABITS(ABITS)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_ind(req0_ind), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_ind(req1_ind), .req1_data(req1_data),
    .wrtEn(wrtEn), .wrtInd(wrtInd), .dIn(dIn),
    .rdInd0(rdInd0), .rdInd1(rdInd1),
    .rfOut0(rfOut0), .rfOut1(rfOut1),
    .dOut0(dOut0), .dOut1(dOut1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wrtEn) rf[wrtInd] <= dIn;
  end

  assign rfOut0 = rf[rdInd0];
  assign rfOut1 = rf[rdInd1];

  task automatic test_reset;
    rst_n = 1'b0; hold = 1'b0;
    req0_valid = 1'b1; req0_ind = 4'd1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_ind = 4'd2; req1_data = 32'h22;
    rdInd0 = 4'd0; rdInd1 = 4'd0;
    #1;
    checks++; if (wrtEn !== 1'b0) begin errors++; $display("FAIL reset_wrtEn got %0b want 0", wrtEn); end
    checks++; if (wrtInd !== 4'd0) begin errors++; $display("FAIL reset_wrtInd got %0d want 0", wrtInd); end
    checks++; if (dIn !== 32'd0) begin errors++; $display("FAIL reset_dIn got %0h want 0", dIn); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    checks++; if (wrtEn !== 1'b0) begin errors++; $display("FAIL reset_held_wrtEn got %0b want 0", wrtEn); end
    @(negedge clk);
    rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_lone;
    @(negedge clk);
    req0_valid = 1'b1; req0_ind = 4'd6; req0_data = 32'd2;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL lone_ready got %b want 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    checks++; if ({wrtEn, wrtInd, dIn} !== {1'b1, 4'd6, 32'd2}) begin errors++; $display("FAIL lone_stage got en=%0b ind=%0d d=%0h want 1/6/2", wrtEn, wrtInd, dIn); end
    @(negedge clk);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (wrtEn !== 1'b0) begin errors++; $display("FAIL lone_wrtEn_off got %0b want 0", wrtEn); end
    rdInd0 = 4'd6; #1;
    checks++; if (dOut0 !== 32'd2) begin errors++; $display("FAIL lone_read got %0h want 2", dOut0); end
    // Lone requester 1 while ptr=PRI1 returns the pointer to PRI0.
    @(negedge clk);
    req1_valid = 1'b1; req1_ind = 4'd11; req1_data = 32'h44;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL lone1_ready got %b want 01", {req0_ready, req1_ready}); end
    @(negedge clk);
    req1_valid = 1'b0;
  endtask

  task automatic test_contention;
    @(negedge clk);
    req0_valid = 1'b1; req0_ind = 4'd8;  req0_data = 32'd5;
    req1_valid = 1'b1; req1_ind = 4'd8;  req1_data = 32'd33;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL cont_g1 got %b want 10", {req0_ready, req1_ready}); end
    @(negedge clk);
    req0_ind = 4'd9; req0_data = 32'd7;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL cont_g2 got %b want 01", {req0_ready, req1_ready}); end
    checks++; if ({wrtInd, dIn} !== {4'd8, 32'd5}) begin errors++; $display("FAIL cont_w1 got %0d/%0h want 8/5", wrtInd, dIn); end
    @(negedge clk);
    req1_ind = 4'd10; req1_data = 32'd1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL cont_g3 got %b want 10", {req0_ready, req1_ready}); end
    checks++; if ({wrtInd, dIn} !== {4'd8, 32'd33}) begin errors++; $display("FAIL cont_w2 got %0d/%0h want 8/21", wrtInd, dIn); end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL cont_g4 got %b want 01", {req0_ready, req1_ready}); end
    checks++; if ({wrtInd, dIn} !== {4'd9, 32'd7}) begin errors++; $display("FAIL cont_w3 got %0d/%0h want 9/7", wrtInd, dIn); end
    @(negedge clk);
    req1_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if ({rf[8], rf[9], rf[10]} !== {32'd33, 32'd7, 32'd1}) begin errors++; $display("FAIL cont_final got r8=%0d r9=%0d r10=%0d want 33/7/1", rf[8], rf[9], rf[10]); end
  endtask

  task automatic test_hold;
    // Lone grant to 0 leaves ptr=PRI1.
    @(negedge clk);
    req0_valid = 1'b1; req0_ind = 4'd12; req0_data = 32'h12;
    @(negedge clk);
    req0_ind = 4'd14; req0_data = 32'h0e;
    req1_valid = 1'b1; req1_ind = 4'd13; req1_data = 32'h13;
    hold = 1'b1;
    #1;
    checks++; if ({wrtEn, wrtInd} !== {1'b1, 4'd12}) begin errors++; $display("FAIL hold_inflight got en=%0b ind=%0d want 1/12", wrtEn, wrtInd); end
    for (int i = 0; i < 3; i++) begin
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL hold_ready[%0d] got %b want 00", i, {req0_ready, req1_ready}); end
      @(posedge clk); #1;
      checks++; if (wrtEn !== 1'b0) begin errors++; $display("FAIL hold_wrtEn[%0d] got %0b want 0", i, wrtEn); end
      @(negedge clk); #1;
    end
    hold = 1'b0;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL hold_release got %b want 01", {req0_ready, req1_ready}); end
    checks++; if (rf[12] !== 32'h12) begin errors++; $display("FAIL hold_commit got %0h want 12", rf[12]); end
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL hold_next got %b want 10", {req0_ready, req1_ready}); end
    @(negedge clk);
    req0_valid = 1'b0;
  endtask

  task automatic test_fwd;
    logic [DBITS-1:0] exp_fwd;
`ifdef RF_ARB_FWD_EN
    exp_fwd = 32'd9;
`else
    exp_fwd = 32'd2;
`endif
    @(negedge clk);
    req0_valid = 1'b1; req0_ind = 4'd6; req0_data = 32'd9;
    rdInd0 = 4'd6; rdInd1 = 4'd6;
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    checks++; if (dOut0 !== exp_fwd) begin errors++; $display("FAIL fwd_dOut0 got %0h want %0h", dOut0, exp_fwd); end
    checks++; if (dOut1 !== exp_fwd) begin errors++; $display("FAIL fwd_dOut1 got %0h want %0h", dOut1, exp_fwd); end
    @(posedge clk); #1;
    checks++; if (dOut0 !== 32'd9) begin errors++; $display("FAIL fwd_after got %0h want 9", dOut0); end
  endtask

  task automatic test_idle;
    rdInd0 = 4'd8; rdInd1 = 4'd10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++; if ({wrtEn, wrtInd, dIn} !== {1'b0, 4'd6, 32'd9}) begin errors++; $display("FAIL idle_stage[%0d] got en=%0b ind=%0d d=%0h want 0/6/9", i, wrtEn, wrtInd, dIn); end
      checks++; if ({dOut0, dOut1} !== {32'd33, 32'd1}) begin errors++; $display("FAIL idle_read[%0d] got %0h/%0h want 21/1", i, dOut0, dOut1); end
    end
  endtask

  task automatic test_reset_midop;
    @(negedge clk);
    req0_valid = 1'b1; req0_ind = 4'd3; req0_data = 32'haa;
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_ind = 4'd4; req1_data = 32'hbb;
    checks++; if (wrtEn !== 1'b1) begin errors++; $display("FAIL midop_pre got %0b want 1", wrtEn); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({wrtEn, wrtInd, dIn} !== {1'b0, 4'd0, 32'd0}) begin errors++; $display("FAIL midop_clear got en=%0b ind=%0d d=%0h want 0/0/0", wrtEn, wrtInd, dIn); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL midop_ready got %b want 00", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    checks++; if (rf[3] !== 32'd0) begin errors++; $display("FAIL midop_dropped got %0h want 0", rf[3]); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL midop_ptr got %b want 10", {req0_ready, req1_ready}); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = '0;
    test_reset();
    test_lone();
    test_contention();
    test_hold();
    test_fwd();
    test_idle();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
